// File: rtl/gate_check_pkg.sv
// gate_check_pkg
// Shared definitions for the gate self-test harness.
//   state_t   : sweep FSM states (IDLE, DRIVE, SAMPLE, DONE)
//   SETTLE_W  : width of the settle interval timer
//   max_vec() : highest input vector index for an n-input gate
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int SETTLE_W = 8;

    function automatic int max_vec(input int n);
        return (1 << n) - 1;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// settle_timer
// Loadable down-counter that marks the end of a settle interval.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset (count returns to 0)
//   load     in   load load_val into the counter (wins over tick)
//   load_val in   SETTLE_W-bit value to load
//   tick     in   decrement by one; holds at zero
//   zero     out  counter currently equals zero
module settle_timer
    import gate_check_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                tick,
    output logic                zero
);

    logic [SETTLE_W-1:0] count_q;
    logic [SETTLE_W-1:0] count_d;

    // Next count: a load takes priority, otherwise tick counts down and
    // parks at zero so the caller can sit on 'zero' without wrapping.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - SETTLE_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/gate_vector_checker.sv
// gate_vector_checker
// Self-test harness for a small combinational gate. Walks every input
// vector into the gate, lets it settle, samples the response and checks
// it against the golden truth table TRUTH (bit i = expected for vector i).
// Optional build macro GATE_CHECK_STOP_ON_FAIL_EN: when defined, the sweep
// ends at the first mismatch instead of covering all vectors.
// Parameters:
//   N_IN   number of gate inputs (1..6)
//   SETTLE cycles a vector is driven before the sample cycle (1..255)
//   TRUTH  expected gate output per vector, 2**N_IN bits
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   start        level; begins a sweep when idle or done
//   dut_in       vector driven to the gate under test
//   dut_out      gate response, synchronous to clk
//   busy         sweep in progress
//   done         sweep finished, held until the next start
//   pass         valid with done; no mismatches seen
//   err_count    mismatches in current/last sweep, saturating at 2**N_IN
//   fail_valid   one-cycle pulse per mismatch
//   fail_vec     vector of the latest mismatch
module gate_vector_checker
    import gate_check_pkg::*;
#(
    parameter int                  N_IN   = 2,
    parameter int                  SETTLE = 4,
    parameter logic [2**N_IN-1:0]  TRUTH  = 4'b1000
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_vec
);

    // The vector counter is one bit wider than dut_in so the terminal
    // compare against the last vector never sees a wrapped value.
    localparam logic [N_IN:0]       VEC_LAST = (N_IN+1)'(max_vec(N_IN));
    localparam logic [N_IN:0]       ERR_MAX  = (N_IN+1)'(max_vec(N_IN) + 1);
    localparam logic [N_IN:0]       ONE      = (N_IN+1)'(1);
    localparam logic [SETTLE_W-1:0] LOAD_VAL = SETTLE_W'(SETTLE - 1);

    state_t          state_q,      state_d;
    logic [N_IN:0]   vec_q,        vec_d;
    logic            busy_q,       busy_d;
    logic            done_q,       done_d;
    logic            pass_q,       pass_d;
    logic [N_IN:0]   err_count_q,  err_count_d;
    logic            fail_valid_q, fail_valid_d;
    logic [N_IN-1:0] fail_vec_q,   fail_vec_d;

    logic timer_load;
    logic timer_tick;
    logic timer_zero;
    logic mismatch;
    logic stop_sweep;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (LOAD_VAL),
        .tick     (timer_tick),
        .zero     (timer_zero)
    );

    assign mismatch = (dut_out != TRUTH[vec_q[N_IN-1:0]]);

    // Sweep sequencing. Loading SETTLE-1 and leaving DRIVE on the cycle the
    // timer reads zero gives exactly SETTLE DRIVE cycles per vector, plus one
    // SAMPLE cycle. DONE behaves like IDLE for start so back-to-back sweeps
    // need no extra cycle. All outputs are computed here and registered.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_count_d  = err_count_q;
        fail_valid_d = 1'b0;
        fail_vec_d   = fail_vec_q;
        timer_load   = 1'b0;
        timer_tick   = 1'b0;
        stop_sweep   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = DRIVE;
                    vec_d       = '0;
                    err_count_d = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    timer_load  = 1'b1;
                end
            end

            DRIVE: begin
                timer_tick = 1'b1;
                if (timer_zero) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                if (mismatch) begin
                    fail_valid_d = 1'b1;
                    fail_vec_d   = vec_q[N_IN-1:0];
                    if (err_count_q != ERR_MAX) begin
                        err_count_d = err_count_q + ONE;
                    end
                end

`ifdef GATE_CHECK_STOP_ON_FAIL_EN
                stop_sweep = (vec_q == VEC_LAST) || mismatch;
`else
                stop_sweep = (vec_q == VEC_LAST);
`endif

                if (stop_sweep) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == '0);
                end else begin
                    state_d    = DRIVE;
                    vec_d      = vec_q + ONE;
                    timer_load = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    assign dut_in     = vec_q[N_IN-1:0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// tb_gate_vector_checker
// Bench for gate_vector_checker: a default AND checker driven by a
// selectable gate model, plus a 3-input XOR checker with SETTLE=1.
module tb_gate_vector_checker;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       start = 1'b0;
    logic       start2 = 1'b0;

    logic [1:0] dutIn;
    logic       dutOut;
    logic       busy, done, pass;
    logic [2:0] errCount;
    logic       failValid;
    logic [1:0] failVec;

    logic [2:0] dutIn2;
    logic       dutOut2;
    logic       busy2, done2, pass2;
    logic [3:0] errCount2;
    logic       failValid2;
    logic [2:0] failVec2;

    int   gateMode = 0;
    logic gateInvert2 = 1'b0;

    int assertCount = 0;
    int failCount = 0;

    typedef struct {
        int mode;
        int expErr;
        int expPass;
        int expMask;
        int expPulses;
        int expFailVec;
    } sweepVec_t;

    sweepVec_t vecTable [4];

    gate_vector_checker #(
        .N_IN   (2),
        .SETTLE (4),
        .TRUTH  (4'b1000)
    ) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .start      (start),
        .dut_in     (dutIn),
        .dut_out    (dutOut),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (errCount),
        .fail_valid (failValid),
        .fail_vec   (failVec)
    );

    gate_vector_checker #(
        .N_IN   (3),
        .SETTLE (1),
        .TRUTH  (8'b10010110)
    ) dutXor (
        .clk        (clk),
        .rst_n      (rstN),
        .start      (start2),
        .dut_in     (dutIn2),
        .dut_out    (dutOut2),
        .busy       (busy2),
        .done       (done2),
        .pass       (pass2),
        .err_count  (errCount2),
        .fail_valid (failValid2),
        .fail_vec   (failVec2)
    );

    // 0: correct AND, 1: stuck-at-1, 2: stuck-at-0, 3: inverted AND (NAND)
    function automatic logic gateModel(input int mode, input logic [1:0] in);
        case (mode)
            0:       return in[0] & in[1];
            1:       return 1'b1;
            2:       return 1'b0;
            default: return ~(in[0] & in[1]);
        endcase
    endfunction

    // Gate under test for the AND checker.
    always_comb dutOut = gateModel(gateMode, dutIn);

    // Gate under test for the XOR checker, optionally inverted.
    always_comb dutOut2 = (^dutIn2) ^ gateInvert2;

    // Free-running clock.
    always #5 clk = ~clk;

    // Guard against a hang anywhere in the sequence.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic resetDut();
        start  = 1'b0;
        start2 = 1'b0;
        rstN   = 1'b0;
        tick();
        tick();
        rstN   = 1'b1;
    endtask

    // Runs one sweep on the AND checker. Index j counts edges after the
    // start edge; vector j/5 is on dut_in until the last SAMPLE at edge 20.
    task automatic applyStimulus(input int mode, input logic holdStart,
                                 output int cycles, output logic [3:0] mask,
                                 output int pulses);
        gateMode = mode;
        mask     = 4'b0000;
        pulses   = 0;
        cycles   = -1;
        start    = 1'b1;
        tick();
        if (!holdStart) start = 1'b0;
        for (int j = 0; j < 200; j++) begin
            if (failValid) begin
                mask[failVec] = 1'b1;
                pulses++;
            end
            if (j < 20) begin
                checkOutput("dut_in_step", int'(dutIn), j / 5);
                checkOutput("busy_in_sweep", int'(busy), 1);
            end
            if (done) begin
                cycles = j;
                break;
            end
            tick();
        end
        checkOutput("sweep_done", int'(done), 1);
    endtask

    // Runs one sweep on the XOR checker; vector j/2 after edge j.
    task automatic runXorSweep(input logic invert, output int cycles);
        gateInvert2 = invert;
        cycles      = -1;
        start2      = 1'b1;
        tick();
        start2      = 1'b0;
        for (int j = 0; j < 200; j++) begin
            if (j < 16) checkOutput("xor_dut_in_step", int'(dutIn2), j / 2);
            if (done2) begin
                cycles = j;
                break;
            end
            tick();
        end
        checkOutput("xor_sweep_done", int'(done2), 1);
    endtask

    initial begin
        int         cycles;
        logic [3:0] mask;
        int         pulses;
        int         n;

        vecTable[0] = '{mode: 0, expErr: 0, expPass: 1, expMask: 4'b0000, expPulses: 0, expFailVec: 0};
        vecTable[1] = '{mode: 1, expErr: 3, expPass: 0, expMask: 4'b0111, expPulses: 3, expFailVec: 2};
        vecTable[2] = '{mode: 2, expErr: 1, expPass: 0, expMask: 4'b1000, expPulses: 1, expFailVec: 3};
        vecTable[3] = '{mode: 3, expErr: 4, expPass: 0, expMask: 4'b1111, expPulses: 4, expFailVec: 3};

        $display("[TB] starting gate_vector_checker test");

        resetDut();
        checkOutput("reset_dut_in", int'(dutIn), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_pass", int'(pass), 0);
        checkOutput("reset_err_count", int'(errCount), 0);
        checkOutput("reset_fail_valid", int'(failValid), 0);
        checkOutput("reset_fail_vec", int'(failVec), 0);

        for (int i = 0; i < 4; i++) begin
            resetDut();
            applyStimulus(vecTable[i].mode, 1'b0, cycles, mask, pulses);
            checkOutput("sweep_latency", cycles, 20);
            checkOutput("sweep_err_count", int'(errCount), vecTable[i].expErr);
            checkOutput("sweep_pass", int'(pass), vecTable[i].expPass);
            checkOutput("sweep_fail_mask", int'(mask), vecTable[i].expMask);
            checkOutput("sweep_fail_pulses", pulses, vecTable[i].expPulses);
            checkOutput("sweep_fail_vec", int'(failVec), vecTable[i].expFailVec);
            checkOutput("sweep_busy_at_done", int'(busy), 0);
            tick();
            checkOutput("done_held", int'(done), 1);
            checkOutput("fail_valid_one_cycle", int'(failValid), 0);
            checkOutput("dut_in_held_last", int'(dutIn), 3);
        end

        // Reset in the middle of a sweep with an inverted gate.
        resetDut();
        gateMode = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        checkOutput("pre_reset_err_count", int'(errCount), 1);
        checkOutput("pre_reset_busy", int'(busy), 1);
        rstN = 1'b0;
        tick();
        checkOutput("midreset_dut_in", int'(dutIn), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_done", int'(done), 0);
        checkOutput("midreset_pass", int'(pass), 0);
        checkOutput("midreset_err_count", int'(errCount), 0);
        checkOutput("midreset_fail_valid", int'(failValid), 0);
        checkOutput("midreset_fail_vec", int'(failVec), 0);
        rstN = 1'b1;
        applyStimulus(3, 1'b0, cycles, mask, pulses);
        checkOutput("post_reset_latency", cycles, 20);
        checkOutput("post_reset_err_count", int'(errCount), 4);
        checkOutput("post_reset_pass", int'(pass), 0);

        // start held high: no mid-sweep restart, then immediate restart.
        resetDut();
        applyStimulus(0, 1'b1, cycles, mask, pulses);
        checkOutput("held_start_latency", cycles, 20);
        checkOutput("held_start_pass", int'(pass), 1);
        tick();
        checkOutput("restart_done_dropped", int'(done), 0);
        checkOutput("restart_busy", int'(busy), 1);
        checkOutput("restart_dut_in", int'(dutIn), 0);
        checkOutput("restart_err_count", int'(errCount), 0);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        checkOutput("restart_latency", n, 20);
        checkOutput("restart_pass", int'(pass), 1);
        start = 1'b0;

        // 3-input XOR checker, SETTLE=1: correct gate, then inverted gate
        // which fails all 8 vectors and hits the saturation ceiling.
        resetDut();
        runXorSweep(1'b0, cycles);
        checkOutput("xor_latency", cycles, 16);
        checkOutput("xor_pass", int'(pass2), 1);
        checkOutput("xor_err_count", int'(errCount2), 0);
        runXorSweep(1'b1, cycles);
        checkOutput("xor_inv_latency", cycles, 16);
        checkOutput("xor_inv_pass", int'(pass2), 0);
        checkOutput("xor_inv_err_count", int'(errCount2), 8);
        checkOutput("xor_inv_fail_vec", int'(failVec2), 7);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
